// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one shared resource to one of W requesters at a time.
// Grants end on done or are force-released after MAX_HOLD cycles; all outputs are registered.
module rr_arbiter #(
    parameter int W        = 8,
    parameter int E        = $clog2(W),
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req,
    input  logic         done,
    output logic [W-1:0] gnt,
    output logic [E-1:0] gnt_enc,
    output logic         gnt_vld,
    output logic         timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e         state_q, state_d;
    logic [E-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [W-1:0]   gnt_q, gnt_d;
    logic [E-1:0]   enc_q, enc_d;
    logic           vld_q, vld_d;
    logic           timeout_q, timeout_d;

    logic           release_ev;
    logic [E-1:0]   arb_ptr;
    logic           win_found;
    logic [E-1:0]   win_idx;
    logic [E-1:0]   probe;

    assign release_ev = (state_q == StBusy) &&
                        (done || (hold_q == HW'(MAX_HOLD - 1)));

    // On release the pointer moves past the owner before re-arbitrating, in the same cycle.
    always_comb begin
        arb_ptr = ptr_q;
        if (release_ev) begin
            arb_ptr = E'((int'(enc_q) + 1) % W);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = 0; k < W; k++) begin
            probe = E'((int'(arb_ptr) + k) % W);
            if (!win_found && req[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        enc_d     = enc_q;
        vld_d     = vld_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StBusy;
                    gnt_d   = W'(1) << win_idx;
                    enc_d   = win_idx;
                    vld_d   = 1'b1;
                    hold_d  = '0;
                end
            end
            StBusy: begin
                if (release_ev) begin
                    ptr_d     = arb_ptr;
                    timeout_d = !done;
                    hold_d    = '0;
                    if (win_found) begin
                        gnt_d = W'(1) << win_idx;
                        enc_d = win_idx;
                        vld_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        enc_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            enc_q     <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            enc_q     <= enc_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_enc = enc_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter W, default 8: number of requesters sharing one resource (W >= 2).
REQ-002 Parameter E, default $clog2(W): width of the encoded grant index.
REQ-003 Parameter MAX_HOLD, default 16: maximum grant duration in cycles before forced release (MAX_HOLD >= 1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  W  per-requester request bits; level-sensitive.
REQ-007 done  input  1  single-cycle pulse from the resource: current owner has finished.
REQ-008 gnt  output  W  one-hot grant vector; all zero when no owner.
REQ-009 gnt_enc  output  E  binary index of the granted requester; 0 when gnt_vld is low.
REQ-010 gnt_vld  output  1  high while a grant is active; equals |gnt.
REQ-011 timeout  output  1  single-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-012 The block has two states: IDLE (no owner) and BUSY (one owner).
REQ-013 gnt, gnt_enc, gnt_vld and timeout are registered outputs driven from state flops; no combinational path from any input to any output.
REQ-014 Arbitration is round-robin: the winner is the lowest index i >= ptr with req[i]=1; if none exists, it is the lowest index i < ptr with req[i]=1.
REQ-015 ptr is an E-bit register; after each grant ends, ptr loads (owner index + 1) modulo W, so ptr wraps from W-1 to 0.
REQ-016 IDLE with |req=1 -> BUSY next cycle; gnt/gnt_enc reflect the winner one cycle after req is sampled.
REQ-017 IDLE with req=0 -> stay IDLE; outputs remain zero.
REQ-018 In BUSY, gnt is held constant until a release event, even if the owner deasserts req.
REQ-019 A release event is done=1 in BUSY, or the hold counter reaching MAX_HOLD-1 in BUSY without done.
REQ-020 On release, the block re-arbitrates in the same cycle using the updated ptr; if any req is set (the previous owner included, at lowest priority) it stays BUSY with the new winner next cycle (back-to-back, zero idle cycles); otherwise it goes to IDLE.
REQ-021 The hold counter clears on every new grant and increments each BUSY cycle; its width is $clog2(MAX_HOLD+1) bits.
REQ-022 timeout pulses high for exactly one cycle, in the cycle after a forced release; it stays low if done and the MAX_HOLD limit coincide (done takes precedence).
REQ-023 done in IDLE is ignored and has no effect on ptr or state.
REQ-024 req bits of indices outside the current winner never change gnt mid-grant.
REQ-025 gnt is always one-hot or zero; gnt_enc always equals the index of the set gnt bit.

Reset
REQ-026 While rst=1: state=IDLE, ptr=0, hold counter=0, gnt=0, gnt_enc=0, gnt_vld=0, timeout=0, asynchronously.
REQ-027 Reset asserted mid-grant immediately drops gnt; after deassertion, arbitration restarts with requester 0 at highest priority.
REQ-028 The first arbitration occurs on the first rising clk edge after rst deasserts.

Verification (W=4, MAX_HOLD=4)
REQ-029 After reset, req=4'b1010 held -> next cycle gnt=4'b0010, gnt_enc=1; done pulse -> next cycle gnt=4'b1000, gnt_enc=3, with no idle cycle.
REQ-030 ptr wrap: owner=3, req=4'b1001, done -> next gnt=4'b0001 (ptr=0); owner 3 regains the grant only after 0 releases.
REQ-031 Owner drops req while granted with no done -> gnt held for 4 cycles, then forced release, timeout=1 for one cycle, state IDLE if req=0.
REQ-032 done and the hold limit in the same cycle -> release occurs, timeout stays 0.
REQ-033 rst pulsed while gnt=4'b0100 -> gnt=0 immediately; after release with req=4'b0110, gnt=4'b0010.
REQ-034 Random req/done stream over 10k cycles -> gnt one-hot or zero at all times, each requester holding req continuously is granted within W grants, and no grant exceeds 4 cycles.
